// File: rtl/systolic_array_os.sv
// Output-stationary fixed-point matrix multiply C = A*W on a ROWS x COLS PE grid.
// x columns of A stream in from the left, w rows of W from the top; C is streamed out row-major.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for an operation; op_rdy high
// S_LOAD  | consuming K paired x/w beats, grid advances on each fire
// S_DRAIN | injecting zeros for ROWS+COLS-1 cycles to flush the skew
// S_OUT   | streaming C[r][c] row-major with last on the final beat
module systolic_array_os #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int NBITS = 16,
   parameter int DBITS = 8,
   parameter int KMAX  = 256,
   localparam int KW   = $clog2(KMAX + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    op_val,
   output logic                    op_rdy,
   input  logic [KW-1:0]           op_k,
   input  logic                    op_acc,
   input  logic [ROWS*NBITS-1:0]   x_recv_msg,
   input  logic                    x_recv_val,
   output logic                    x_recv_rdy,
   input  logic [COLS*NBITS-1:0]   w_recv_msg,
   input  logic                    w_recv_val,
   output logic                    w_recv_rdy,
   output logic [NBITS-1:0]        out_send_msg,
   output logic                    out_send_val,
   input  logic                    out_send_rdy,
   output logic                    out_send_last
);
   localparam int CW = $clog2(KMAX + ROWS + COLS + 1);
   localparam int OW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

   state_t                   r_state, w_next;
   logic                     r_alive;
   logic [CW-1:0]            r_cnt;
   logic [OW-1:0]            r_oidx;
   logic signed [NBITS-1:0]  r_acc  [ROWS*COLS];
   logic signed [NBITS-1:0]  r_xr   [ROWS][COLS];
   logic signed [NBITS-1:0]  r_wr   [ROWS][COLS];
   logic signed [NBITS-1:0]  w_xnew [ROWS];
   logic signed [NBITS-1:0]  w_wnew [COLS];
   logic signed [NBITS-1:0]  w_xsk  [ROWS];
   logic signed [NBITS-1:0]  w_wsk  [COLS];
   logic signed [NBITS-1:0]  w_xin  [ROWS][COLS];
   logic signed [NBITS-1:0]  w_win  [ROWS][COLS];
   logic signed [NBITS-1:0]  w_mac  [ROWS][COLS];
   logic signed [2*NBITS-1:0] w_prod [ROWS][COLS];
   logic                     w_op_fire, w_beat, w_adv, w_out_fire, w_last;

   assign w_op_fire  = op_val && op_rdy;
   assign w_beat     = (r_state == S_LOAD) && x_recv_val && w_recv_val;
   assign w_adv      = w_beat || (r_state == S_DRAIN);
   assign w_last     = (r_oidx == OW'(ROWS * COLS - 1));
   assign w_out_fire = out_send_val && out_send_rdy;

   assign op_rdy        = r_alive && (r_state == S_IDLE);
   assign x_recv_rdy    = (r_state == S_LOAD) && w_recv_val;
   assign w_recv_rdy    = (r_state == S_LOAD) && x_recv_val;
   assign out_send_val  = (r_state == S_OUT);
   assign out_send_last = (r_state == S_OUT) && w_last;
   assign out_send_msg  = (r_state == S_OUT) ? r_acc[r_oidx] : '0;

   // Row i of x and column j of w are delayed i and j advances so operands meet on the wavefront.
   for (genvar i = 0; i < ROWS; i++) begin : g_xsk
      assign w_xnew[i] = (r_state == S_LOAD) ? x_recv_msg[i*NBITS +: NBITS] : '0;
      if (i == 0) begin : g_direct
         assign w_xsk[i] = w_xnew[i];
      end else begin : g_delay
         logic signed [NBITS-1:0] r_sk [i];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < i; s++) r_sk[s] <= '0;
            end else if (w_adv) begin
               r_sk[0] <= w_xnew[i];
               for (int s = 1; s < i; s++) r_sk[s] <= r_sk[s-1];
            end
         end
         assign w_xsk[i] = r_sk[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_wsk
      assign w_wnew[j] = (r_state == S_LOAD) ? w_recv_msg[j*NBITS +: NBITS] : '0;
      if (j == 0) begin : g_direct
         assign w_wsk[j] = w_wnew[j];
      end else begin : g_delay
         logic signed [NBITS-1:0] r_sk [j];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < j; s++) r_sk[s] <= '0;
            end else if (w_adv) begin
               r_sk[0] <= w_wnew[j];
               for (int s = 1; s < j; s++) r_sk[s] <= r_sk[s-1];
            end
         end
         assign w_wsk[j] = r_sk[j-1];
      end
   end

   always_comb begin
      for (int i = 0; i < ROWS; i++) begin
         w_xin[i][0] = w_xsk[i];
         for (int j = 1; j < COLS; j++) w_xin[i][j] = r_xr[i][j-1];
      end
      for (int j = 0; j < COLS; j++) begin
         w_win[0][j] = w_wsk[j];
         for (int i = 1; i < ROWS; i++) w_win[i][j] = r_wr[i-1][j];
      end
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            w_prod[i][j] = w_xin[i][j] * w_win[i][j];
            w_mac[i][j]  = NBITS'(w_prod[i][j] >>> DBITS);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
               r_xr[i][j]         <= '0;
               r_wr[i][j]         <= '0;
               r_acc[i*COLS + j]  <= '0;
            end
         end
      end else if (w_op_fire && !op_acc) begin
         for (int k = 0; k < ROWS * COLS; k++) r_acc[k] <= '0;
      end else if (w_adv) begin
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
               r_xr[i][j]        <= w_xin[i][j];
               r_wr[i][j]        <= w_win[i][j];
               r_acc[i*COLS + j] <= r_acc[i*COLS + j] + w_mac[i][j];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_alive <= 1'b0;
         r_cnt   <= '0;
         r_oidx  <= '0;
      end else begin
         r_state <= w_next;
         r_alive <= 1'b1;
         case (r_state)
            S_IDLE:  if (w_op_fire) r_cnt <= CW'(op_k);
            S_LOAD:  if (w_beat) r_cnt <= (r_cnt == CW'(1)) ? CW'(ROWS + COLS - 1) : r_cnt - CW'(1);
            S_DRAIN: r_cnt <= r_cnt - CW'(1);
            S_OUT:   if (w_out_fire) r_oidx <= w_last ? '0 : r_oidx + OW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_op_fire) w_next = (op_k == '0) ? S_OUT : S_LOAD;
         S_LOAD:  if (w_beat && r_cnt == CW'(1)) w_next = S_DRAIN;
         S_DRAIN: if (r_cnt == CW'(1)) w_next = S_OUT;
         S_OUT:   if (w_out_fire && w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
endmodule
